bnn_fc_sequencer: RTL and testbench

- Sequences one binary fully-connected layer through the shared, fully pipelined 784-input adder tree. The tree accepts one new neuron vector per cycle and has no stall.
- Issues one neuron per cycle by index to the weight memory, which has a 1-cycle synchronous read. The external XNOR/popcount-prep logic feeds the tree.
- Tracks in-flight neurons through a tag pipeline, captures each tree sum and thresholds it to a binary activation.
- Sits between the layer controller (start/done) and the activation buffer (result write).

---
 rtl/bnn_fc_sequencer.sv | 140 ++++++++++++++
 tb/tb_bnn_fc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_fc_sequencer.sv
// Issues one binary FC layer neuron-by-neuron into a stall-free adder tree and
// thresholds each returning sum into a binary activation.
module bnn_fc_sequencer #(
    parameter int WIDTH_IN    = 8,
    parameter int NUM_NEURONS = 10,
    parameter int ADD_LATENCY = 7,
    parameter int IDX_W       = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       hold,
    input  logic signed [WIDTH_IN+10:0] threshold,
    output logic                       weight_rd_en,
    output logic [IDX_W-1:0]           weight_rd_addr,
    input  logic signed [WIDTH_IN+10:0] tree_sum,
    output logic                       result_valid,
    output logic [IDX_W-1:0]           result_idx,
    output logic signed [WIDTH_IN+10:0] result_sum,
    output logic                       result_bit,
    output logic                       busy,
    output logic                       done
);

    localparam int               SUM_W    = WIDTH_IN + 11;
    localparam int               STAGES   = ADD_LATENCY + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         cnt;
    logic [IDX_W-1:0]         cnt_nxt;
    logic                     rd_en_nxt;
    logic [IDX_W-1:0]         rd_addr_nxt;
    logic                     busy_nxt;
    logic                     load_thr;
    logic signed [SUM_W-1:0]  thr_q;

    logic [STAGES-1:0]        vld_p;
    logic [IDX_W-1:0]         idx_p [STAGES];

    function automatic logic activate(input logic signed [SUM_W-1:0] sum,
                                      input logic signed [SUM_W-1:0] thr);
        return sum >= thr;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The first index goes out on the same edge that accepts start, so busy and
    // the first read strobe both appear in the cycle after start.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = weight_rd_addr;
        busy_nxt    = busy;
        load_thr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_thr    = 1'b1;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    cnt_nxt     = IDX_W'(1);
                    busy_nxt    = 1'b1;
                    state_nxt   = (NUM_NEURONS == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = cnt;
                    cnt_nxt     = cnt + 1'b1;
                    if (cnt == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            weight_rd_en   <= 1'b0;
            weight_rd_addr <= '0;
            busy           <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            weight_rd_en   <= rd_en_nxt;
            weight_rd_addr <= rd_addr_nxt;
            busy           <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load_thr) thr_q <= threshold;
    end

    // p0: tag enters alongside weight read data; p(STAGES-1): aligned with tree_sum
    always_ff @(posedge clk) begin
        if (rst) vld_p <= '0;
        else     vld_p <= {vld_p[STAGES-2:0], weight_rd_en};
    end

    always_ff @(posedge clk) begin
        idx_p[0] <= weight_rd_addr;
        for (int i = 1; i < STAGES; i++) idx_p[i] <= idx_p[i-1];
    end

    // result stage: capture tree output and threshold it
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            result_idx   <= '0;
            result_sum   <= '0;
            result_bit   <= 1'b0;
        end else begin
            result_valid <= vld_p[STAGES-1];
            done         <= vld_p[STAGES-1] && (idx_p[STAGES-1] == LAST_IDX);
            if (vld_p[STAGES-1]) begin
                result_idx <= idx_p[STAGES-1];
                result_sum <= tree_sum;
                result_bit <= activate(tree_sum, thr_q);
            end
        end
    end

endmodule

// File: tb/tb_bnn_fc_sequencer.sv
// Scoreboard bench: a tree/weight-memory model feeds sums by issued index and a
// monitor compares every result against expectations queued at issue time.
module tb_bnn_fc_sequencer;

    localparam int N  = 10;
    localparam int L  = 7;
    localparam int W  = 8;
    localparam int SW = W + 11;
    localparam int IW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 a_start, a_hold, a_rd_en, a_rv, a_bit, a_busy, a_done;
    logic signed [SW-1:0] a_thr, a_tree, a_sum;
    logic [IW-1:0]        a_rd_addr, a_idx;
    logic                 b_start, b_hold, b_rd_en, b_rv, b_bit, b_busy, b_done;
    logic signed [SW-1:0] b_thr, b_tree, b_sum;
    logic [IW-1:0]        b_rd_addr, b_idx;

    bnn_fc_sequencer #(.WIDTH_IN(W), .NUM_NEURONS(N), .ADD_LATENCY(L), .IDX_W(IW)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .hold(a_hold), .threshold(a_thr),
        .weight_rd_en(a_rd_en), .weight_rd_addr(a_rd_addr), .tree_sum(a_tree),
        .result_valid(a_rv), .result_idx(a_idx), .result_sum(a_sum), .result_bit(a_bit),
        .busy(a_busy), .done(a_done));

    bnn_fc_sequencer #(.WIDTH_IN(W), .NUM_NEURONS(1), .ADD_LATENCY(L), .IDX_W(IW)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .hold(b_hold), .threshold(b_thr),
        .weight_rd_en(b_rd_en), .weight_rd_addr(b_rd_addr), .tree_sum(b_tree),
        .result_valid(b_rv), .result_idx(b_idx), .result_sum(b_sum), .result_bit(b_bit),
        .busy(b_busy), .done(b_done));

    typedef struct {
        int     idx;
        longint sum;
        bit     b;
        int     due;
    } exp_t;

    int                   checks = 0;
    int                   failures = 0;
    int                   cyc = 0;
    bit                   mon_en = 0;
    bit                   layer_active = 0;
    int                   start_cyc = 1 << 30;
    int                   issue_cnt, res_cnt, done_cnt, done_cyc;
    logic signed [SW-1:0] thr_l;
    logic signed [SW-1:0] sums [N];
    exp_t                 q [$];
    bit                   dl_v [L+2];
    int                   dl_i [L+2];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, a_rd_en, 0);
        check({tag, "_rd_addr"}, a_rd_addr, 0);
        check({tag, "_result_valid"}, a_rv, 0);
        check({tag, "_result_idx"}, a_idx, 0);
        check({tag, "_result_sum"}, a_sum, 0);
        check({tag, "_result_bit"}, a_bit, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_done"}, a_done, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Environment model (weight memory + adder tree) and output monitor.
    always @(posedge clk) begin
        exp_t e;
        bit   exp_en;
        #1;
        for (int i = L + 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_i[i] = dl_i[i-1];
        end
        dl_v[0] = (a_rd_en === 1'b1);
        dl_i[0] = int'(a_rd_addr);
        if (dl_v[L+1] && dl_i[L+1] < N) a_tree = sums[dl_i[L+1]];
        else                            a_tree = SW'($urandom);

        if (mon_en) begin
            exp_en = 1'b0;
            if (layer_active && issue_cnt < N) begin
                if (cyc == start_cyc + 1)      exp_en = 1'b1;
                else if (cyc >= start_cyc + 2) exp_en = !a_hold;
            end
            check("weight_rd_en", a_rd_en, exp_en);
            if (a_rd_en === 1'b1 && layer_active && issue_cnt < N) begin
                check("weight_rd_addr", a_rd_addr, issue_cnt);
                e.idx = issue_cnt;
                e.sum = sums[issue_cnt];
                e.b   = (sums[issue_cnt] >= thr_l);
                e.due = cyc + 2 + L;
                q.push_back(e);
                issue_cnt++;
            end

            if (a_rv === 1'b1) begin
                check("result_idx", a_idx, (q.size() > 0) ? q[0].idx : -1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("result_sum", a_sum, e.sum);
                    check("result_bit", a_bit, e.b);
                    check("result_cycle", cyc, e.due);
                    check("done_on_last", a_done, (e.idx == N - 1));
                end
                res_cnt++;
                if (a_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end else begin
                check("done_without_result", a_done, 0);
            end
            if (layer_active)
                check("busy", a_busy, (cyc >= start_cyc + 1 && (done_cyc < 0 || cyc <= done_cyc)));
        end
    end

    task automatic fill_random(input int t);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) sums[i] = SW'(t + int'($urandom_range(0, 6)) - 3);
            else                           sums[i] = SW'($urandom);
        end
    endtask

    task automatic run_layer(input logic signed [SW-1:0] thr, input logic [63:0] hmask,
                             input bit pulse, input int rst_at, input int exp_done);
        bit fin;
        fin = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        a_thr   = thr;
        thr_l   = thr;
        a_hold  = hmask[0];
        start_cyc = cyc;
        issue_cnt = 0;
        res_cnt   = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        layer_active = 1'b1;
        q.delete();
        for (int k = 1; k < 200 && !fin; k++) begin
            @(negedge clk);
            a_start = pulse && (k == 6);
            a_thr   = SW'($urandom);
            a_hold  = (k < 64) ? hmask[k] : 1'b0;
            if (rst_at > 0) begin
                if (k == rst_at) begin
                    rst = 1'b1;
                    layer_active = 1'b0;
                    q.delete();
                end else if (k == rst_at + 1) begin
                    rst = 1'b0;
                    check_zero("after_rst");
                end
                if (k > rst_at) check("busy_after_rst", a_busy, 0);
                if (k == rst_at + 16) fin = 1'b1;
            end else if (done_cnt > 0) begin
                a_start = pulse;
                a_hold  = 1'b0;
                fin     = 1'b1;
                check("issued_count", issue_cnt, N);
                check("result_count", res_cnt, N);
                check("done_pulses", done_cnt, 1);
                check("queue_drained", q.size(), 0);
                if (exp_done >= 0) check("done_cycle", done_cyc - start_cyc, exp_done);
            end
        end
        if (!fin) check("layer_finished", done_cnt, 1);
        a_hold = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        a_start = 1'b0; a_hold = 1'b0; a_thr = '0; a_tree = '0;
        b_start = 1'b0; b_hold = 1'b0; b_thr = '0; b_tree = 19'sd123;
        for (int i = 0; i < L + 2; i++) begin dl_v[i] = 1'b0; dl_i[i] = 0; end
        for (int i = 0; i < N; i++) sums[i] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_b_busy", b_busy, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic layer: sums idx-5 against threshold 0.
        for (int i = 0; i < N; i++) sums[i] = SW'(i - 5);
        run_layer(19'sd0, 64'd0, 1'b0, 0, 19);

        // Hold bubble: blocks issue in the 3rd and 4th issue cycles.
        t = int'($urandom_range(0, 400)) - 200;
        fill_random(t);
        run_layer(SW'(t), 64'h0000_0000_0000_000C, 1'b0, 0, 21);

        // Signed threshold boundary around -3.
        fill_random(-3);
        sums[0] = -19'sd4; sums[1] = -19'sd3; sums[2] = -19'sd2;
        run_layer(-19'sd3, 64'd0, 1'b0, 0, 19);

        // Start pulses mid-layer and on done, then an immediate fresh layer.
        fill_random(50);
        run_layer(19'sd50, 64'd0, 1'b1, 0, 19);
        fill_random(-70);
        run_layer(-19'sd70, 64'd0, 1'b0, 0, 19);

        // Reset mid-layer, then a clean layer afterwards.
        fill_random(0);
        run_layer(19'sd0, 64'd0, 1'b0, 8, -1);
        fill_random(10);
        run_layer(19'sd10, 64'd0, 1'b0, 0, 19);

        for (int r = 0; r < 8; r++) begin
            t = int'($urandom_range(0, 4000)) - 2000;
            fill_random(t);
            run_layer(SW'(t), {$urandom, $urandom} & {$urandom, $urandom}, 1'b0, 0, -1);
        end

        // Single-neuron instance.
        @(negedge clk);
        mon_en  = 1'b0;
        b_start = 1'b1;
        b_thr   = 19'sd123;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_thr   = SW'($urandom);
            b_hold  = k[0];
            check("n1_rd_en", b_rd_en, (k == 1));
            check("n1_result_valid", b_rv, (k == 10));
            check("n1_done", b_done, (k == 10));
            check("n1_busy", b_busy, (k >= 1 && k <= 10));
            if (k == 10) begin
                check("n1_result_idx", b_idx, 0);
                check("n1_result_sum", b_sum, 123);
                check("n1_result_bit", b_bit, 1);
            end
        end
        b_hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
